// File: rtl/down_counter.sv
// Loadable down counter with one-shot/periodic modes, pause/resume and a
// registered terminal-count pulse. All state clears asynchronously on reset.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  // Encoding chosen so busy and done are each a single flop bit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] rld, rld_nx;
  logic             tc_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q     <= ZERO;
      rld   <= ZERO;
      tc    <= 1'b0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      rld   <= rld_nx;
      tc    <= tc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    q_nx     = q;
    rld_nx   = rld;
    tc_nx    = 1'b0;
    if (load) begin
      rld_nx   = load_val;
      q_nx     = load_val;
      state_nx = IDLE;
    end else if (stop) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (q != ZERO) begin
              state_nx = RUN;
            end else begin
              state_nx = DONE;
              tc_nx    = 1'b1;
            end
          end
        end
        RUN: begin
          // q == 0 is the one-shot / periodic decision point; count never wraps.
          if (q == ONE) begin
            q_nx  = ZERO;
            tc_nx = 1'b1;
          end else if (q != ZERO) begin
            q_nx = q - ONE;
          end else if (mode && (rld != ZERO)) begin
            q_nx = rld;
          end else begin
            state_nx = DONE;
          end
        end
        DONE: begin
          if (start) begin
            if (rld != ZERO) begin
              q_nx     = rld;
              state_nx = RUN;
            end else begin
              tc_nx = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = state[0];
  assign done = state[1];

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: a behavioural model predicts each edge's
// outputs into a queue, and an independent monitor checks them after the edge.
module tb_down_counter;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             tc;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .mode(mode),
    .q(q), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int busy;
    int done;
    int tc;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model state: m_phase 0 = idle, 1 = counting, 2 = finished.
  int m_q = 0;
  int m_rld = 0;
  int m_phase = 0;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    int   tcv;
    tcv = 0;
    if (load) begin
      m_q = int'(load_val);
      m_rld = int'(load_val);
      m_phase = 0;
    end else if (stop) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        if (m_q == 0) begin
          m_phase = 2;
          tcv = 1;
        end else begin
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (m_q > 1) m_q = m_q - 1;
      else if (m_q == 1) begin
        m_q = 0;
        tcv = 1;
      end else if (mode && m_rld > 0) m_q = m_rld;
      else m_phase = 2;
    end else begin
      if (start) begin
        if (m_rld > 0) begin
          m_q = m_rld;
          m_phase = 1;
        end else begin
          tcv = 1;
        end
      end
    end
    e.q = m_q;
    e.busy = (m_phase == 1) ? 1 : 0;
    e.done = (m_phase == 2) ? 1 : 0;
    e.tc = tcv;
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic ld, input int lv, input logic st, input logic sp, input logic md);
    @(negedge clk);
    load = ld;
    load_val = WIDTH'(lv);
    start = st;
    stop = sp;
    mode = md;
    model_step();
  endtask

  // Pulse reset between edges with no prediction outstanding; outputs must clear at once.
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tc", int'(tc), 0);
    reset = 1'b0;
    m_q = 0;
    m_rld = 0;
    m_phase = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("q", int'(q), e.q);
        chk("busy", int'(busy), e.busy);
        chk("done", int'(done), e.done);
        chk("tc", int'(tc), e.tc);
        chk("busy_done_excl", int'(busy & done), 0);
      end
    end
  end

  initial begin : driver
    bit md;
    reset = 1'b1;
    load = 1'b0;
    load_val = '0;
    start = 1'b0;
    stop = 1'b0;
    mode = 1'b0;
    #3;
    chk("init_q", int'(q), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    chk("init_tc", int'(tc), 0);
    #9 reset = 1'b0;

    // One-shot from 5: 5,5,4,3,2,1,0 then DONE.
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (7) cyc(0, 0, 0, 0, 0);

    // Periodic from 3: tc every 4 cycles.
    cyc(1, 3, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    repeat (12) cyc(0, 0, 0, 0, 1);

    // Pause at 6, hold, resume.
    cyc(1, 9, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);

    // All three commands together while running: load wins.
    cyc(1, 7, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 2, 1, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Zero load: start goes straight to DONE with tc, again on a second start.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Reset mid-run at q = 2, then remain idle at 0.
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    reset_pulse();
    repeat (3) cyc(0, 0, 0, 0, 0);

    // Randomized traffic including mid-run mode flips and occasional resets.
    md = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      if ($urandom_range(0, 149) == 0) reset_pulse();
      cyc(($urandom_range(0, 15) == 0), int'($urandom_range(0, (1 << WIDTH) - 1)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), md);
    end
    cyc(0, 0, 0, 0, md);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    if (sbq.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
